// File: rtl/serial_add_ctrl.sv
//==============================================================================
// serial_add_ctrl : bit-serial adder built around one shared half-adder cell
// Revision: 1.0
//==============================================================================
`default_nettype none

module Half_Adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int IDX_W = $clog2(WIDTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PH1  = 2'd1,
    PH2  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, s_sr, s_next;
  logic [IDX_W-1:0] idx;
  logic             carry, p, g;
  logic             ha_a, ha_b, ha_s, ha_c;
  logic             last_bit;

  assign last_bit = (idx == LAST_IDX);

  Half_Adder u_ha (
    .a (ha_a),
    .b (ha_b),
    .s (ha_s),
    .c (ha_c)
  );

  // New sum bit enters at the MSB so the LSB-first walk ends fully aligned
  generate
    if (WIDTH == 1) begin : g_w1
      assign s_next = ha_s;
    end else begin : g_wn
      assign s_next = {ha_s, s_sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ha_a       = 1'b0;
    ha_b       = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = PH1;
      PH1: begin
        busy       = 1'b1;
        ha_a       = a_sr[0];
        ha_b       = b_sr[0];
        state_next = PH2;
      end
      PH2: begin
        busy       = 1'b1;
        ha_a       = p;
        ha_b       = carry;
        state_next = last_bit ? DONE : PH1;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr  <= '0;
      b_sr  <= '0;
      s_sr  <= '0;
      idx   <= '0;
      carry <= 1'b0;
      p     <= 1'b0;
      g     <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_sr  <= a;
          b_sr  <= b;
          carry <= 1'b0;
          idx   <= '0;
        end
        PH1: begin
          p <= ha_s;
          g <= ha_c;
        end
        PH2: begin
          // g and ha_c are mutually exclusive, so OR forms the full-adder carry
          carry <= g | ha_c;
          s_sr  <= s_next;
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          if (last_bit) begin
            sum  <= s_next;
            cout <= g | ha_c;
          end else begin
            idx <= idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial adder controller that time-multiplexes a single half-adder cell to add two WIDTH-bit operands. A one-cycle start pulse launches an addition. The controller then walks the operands LSB-first, using two half-adder phases per bit plus a carry flip-flop. It presents the registered sum and carry-out with a one-cycle done pulse. It sits between a requesting datapath and the existing half-adder cell (Half_Adder), which it instantiates exactly once.

## Interface
- WIDTH, default 8: operand/sum width in bits; legal range 1..32.
- clk  in  1  rising-edge clock; the single clock of the block.
- rst_n  in  1  asynchronous active-low reset; clears all state immediately.
- start  in  1  request pulse; sampled only in IDLE.
- a  in  WIDTH  operand A; captured on the accepting edge.
- b  in  WIDTH  operand B; captured on the accepting edge.
- busy  out  1  high while in PH1/PH2.
- done  out  1  one-cycle pulse; sum/cout valid from this cycle onward.
- sum  out  WIDTH  registered result, (a+b) mod 2^WIDTH; held until the next completion.
- cout  out  1  registered carry-out of the addition; held with sum.

## Operation
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0; internal shift registers, index, carry and phase registers all 0.
- Internal state:
  - a_sr, b_sr, s_sr: WIDTH-bit shift registers.
  - carry: 1 bit.
  - p, g: phase-1 results.
  - idx: ceil(log2(WIDTH+1)) bits.
- The half-adder inputs are muxed by state: PH1 drives (a_sr[0], b_sr[0]); PH2 drives (p, carry); IDLE/DONE drive (0, 0).
- FSM states: IDLE, PH1, PH2, DONE.
- IDLE, start=1: a_sr<=a, b_sr<=b, carry<=0, idx<=0 -> PH1.
- IDLE, start=0: stay.
- PH1: p<=ha.s, g<=ha.c -> PH2.
- PH2: the result bit is ha.s; carry<=g|ha.c; s_sr<={ha.s, s_sr[WIDTH-1:1]}; a_sr, b_sr shift right by one.
  - If idx==WIDTH-1: sum<={ha.s, s_sr[WIDTH-1:1]}, cout<=g|ha.c -> DONE.
  - Otherwise: idx<=idx+1 -> PH1.
- DONE: done=1 -> IDLE unconditionally.
- start is ignored in PH1, PH2 and DONE; no queuing.
- Changes on a/b after acceptance have no effect.
- The g and ha.c terms in PH2 are never both 1; carry is their OR.
- sum/cout change only on the PH2->DONE edge; between completions they hold the previous result.
- Reset asserted mid-operation aborts the addition; outputs return to 0; no done pulse is generated.

## Timing
- Start accepted at edge k (state IDLE, start=1).
- busy=1 from after edge k through edge k+2*WIDTH.
- sum/cout updated at edge k+2*WIDTH.
- done=1 for exactly the cycle following edge k+2*WIDTH.
- Latency from the accepting edge to done: 2*WIDTH cycles.
- Back-to-back throughput: one addition per 2*WIDTH+2 cycles, because start is accepted only in IDLE.
- busy and done are never high simultaneously.
- busy and done are Moore outputs of the state register, with no combinational path from start.
- WIDTH=1: PH1, PH2, DONE; latency 2 cycles.

## Test plan
- Reset then idle: all outputs 0 while rst_n=0; with no start for 20 cycles, busy=0 and done=0.
- WIDTH=8, a=0x5A, b=0x3C, start pulse at edge k -> busy high 16 cycles; done at the cycle after edge k+16; sum=0x96, cout=0; outputs hold after done.
- WIDTH=8, a=0xFF, b=0x01 -> sum=0x00, cout=1 (full carry ripple). Then a=0xFF, b=0xFF -> sum=0xFE, cout=1.
- Start re-pulsed in PH1, PH2 and DONE of an addition of a=0x12, b=0x34 (other a/b values driven) -> ignored; sum=0x46, cout=0. A start in the IDLE cycle after done is accepted with new operands.
- rst_n pulled low asynchronously at cycle 7 of an addition of 0xAA+0x55 -> busy, sum and cout read 0 immediately; no done pulse. A fresh start after release yields sum=0xFF, cout=0.
- Parameter sweep WIDTH=1 (1+1 -> sum=0, cout=1, done 2 cycles after accept) and WIDTH=32 with random operands against a reference model: latency 64, sum and cout exact.
